// File: rtl/acumulador_soma.sv
// ---------------------------------------------------------------------------
// acumulador_soma
//
// Purpose:
//   Sits after the 4-bit full adder stage. Each adder result {ccout, ss} is an
//   unsigned value from 0 to 31. A run adds up `len` of these results in an
//   ACC_W-bit accumulator. The block then holds the final total until the
//   consumer takes it. A sticky flag records overflow of the accumulator
//   during the run.
//
// Optional feature (macro ACUMULADOR_SATURATE_EN):
//   defined   -> on overflow acc clamps to all-ones and stays there for the
//                rest of the run.
//   undefined -> on overflow acc wraps to the low ACC_W bits of the sum.
//   In both builds ovf is set on overflow.
//
// Handshake rules (both ports):
//   A transfer happens only on a rising clk edge where valid && ready.
//   Input port : in_valid/in_ready. in_ready is high only in ACC. in_ready
//                depends only on state, so it never depends on in_valid.
//   Output port: out_valid/out_ready. out_valid is high only in DONE. acc and
//                ovf hold steady for as long as out_valid=1 and out_ready=0.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   start      request a new run (IDLE, or DONE together with out_ready)
//   len[3:0]   number of results in the run; latched when start is accepted
//   in_valid   adder result on ss/ccout is valid
//   in_ready   block accepts a result this cycle
//   ss[3:0]    sum bits from the adder
//   ccout      carry-out from the adder
//   acc        accumulated total (registered)
//   ovf        sticky overflow flag for the current run
//   out_valid  acc holds the final total of a completed run
//   out_ready  consumer takes the total
//   busy       run in progress (state ACC)
// ---------------------------------------------------------------------------
module acumulador_soma #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ss,
  input  logic             ccout,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       len_q, len_d;

  logic [ACC_W:0]   sample_ext;
  logic [ACC_W:0]   sum;
  logic             start_accept;

  // The 5-bit sample is zero-extended to ACC_W+1 bits. The extra MSB of the
  // sum is then the overflow indication.
  assign sample_ext = {{(ACC_W-4){1'b0}}, ccout, ss};
  assign sum        = {1'b0, acc_q} + sample_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    start_accept = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // in_valid is ignored here; only start matters.
        if (start) start_accept = 1'b1;
      end

      ST_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + 4'd1;
`ifdef ACUMULADOR_SATURATE_EN
          // After the first overflow acc already holds all-ones. It stays
          // pinned there for the remainder of the run.
          if (ovf_q) begin
            acc_d = acc_q;
          end else if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
`else
          acc_d = sum[ACC_W-1:0];
          if (sum[ACC_W]) ovf_d = 1'b1;
`endif
          // len_q is never 0 in ACC, so len_q-1 cannot underflow here.
          if (cnt_q == len_q - 4'd1) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        // A start while the total is being taken is a back-to-back restart.
        // A start without out_ready is ignored.
        if (out_ready) begin
          if (start) start_accept = 1'b1;
          else       state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A new run clears the total and the flag. An empty run (len=0) goes
    // straight to DONE with a total of zero.
    if (start_accept) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      len_d   = len;
      state_d = (len == 4'd0) ? ST_DONE : ST_ACC;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule
